pipeline_stall_controller: RTL and testbench

- Sequences the 5-stage MIPS pipeline: generates per-stage register enables, IF/ID flush and ID/EX bubble insertion.
- Handles three hazard classes:
  - load-use interlock: 1-cycle stall;
  - data-memory wait: full freeze until ready;
  - taken branch resolved in EX: 2-instruction squash.
- Sits beside the dependency/forwarding block, which keeps operand-mux selection. This block owns only stall and flush sequencing.
- Keeps its own copy of instruction metadata for the EX and MEM stages.

---
 rtl/mips_pipe_pkg.sv | 34 +++
 rtl/ins_meta_decode.sv | 33 +++
 rtl/pipeline_stall_controller.sv | 138 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: opcodes, instruction
// field positions, controller state encoding and the per-stage metadata record.
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b010100;
  localparam logic [5:0] OP_STORE = 6'b010101;
  localparam logic [5:0] OP_BEQ   = 6'b110000;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
    logic       is_store;
    logic       writes;
  } meta_t;

  localparam meta_t META_NONE = '0;

endpackage

// File: rtl/ins_meta_decode.sv
// Combinational instruction classifier: opcode class, destination, sources and
// whether the second source field is actually read.
module ins_meta_decode
  import mips_pipe_pkg::*;
(
  input  logic [31:0] ins,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        writes,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs2
);

  logic [5:0] op;
  logic       unused_low_bits;

  assign op              = ins[OP_HI:OP_LO];
  assign rd              = ins[RD_HI:RD_LO];
  assign rs1             = ins[RS1_HI:RS1_LO];
  assign rs2             = ins[RS2_HI:RS2_LO];
  assign unused_low_bits = ^ins[RS2_LO-1:0];

  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BEQ);
  // r0 is hardwired, so a write to it is treated as no write at all
  assign writes    = !is_store && !is_branch && (rd != 5'd0);
  assign uses_rs2  = (op == OP_RTYPE) || is_store;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, data-memory
// freeze and taken-branch squash, with a stall counter and sticky memory timeout.
module pipeline_stall_controller
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins_id,
  input  logic             ins_valid,
  input  logic             branch_taken_ex,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  logic        d_is_load;
  logic        d_is_store;
  logic        d_is_branch;
  logic        d_writes;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_uses_rs2;
  logic        unused_branch;

  meta_t       ex_m;
  meta_t       mem_m;
  meta_t       id_meta;
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [WAIT_W-1:0] wait_cnt;

  logic        mw;
  logic        br;
  logic        lu;
  logic        src_hit;

  ins_meta_decode u_decode (
    .ins       (ins_id),
    .is_load   (d_is_load),
    .is_store  (d_is_store),
    .is_branch (d_is_branch),
    .writes    (d_writes),
    .rd        (d_rd),
    .rs1       (d_rs1),
    .rs2       (d_rs2),
    .uses_rs2  (d_uses_rs2)
  );

  assign unused_branch = d_is_branch;

  // Gating on ins_valid keeps an undriven ins_id out of the metadata path
  assign id_meta = ins_valid ? '{valid: 1'b1, rd: d_rd, is_load: d_is_load,
                                 is_store: d_is_store, writes: d_writes}
                             : META_NONE;

  assign src_hit = (ex_m.rd == d_rs1) || (d_uses_rs2 && (ex_m.rd == d_rs2));
  assign mw = mem_m.valid && (mem_m.is_load || mem_m.is_store) && !mem_ready;
  assign br = branch_taken_ex;
  assign lu = ex_m.valid && ex_m.is_load && ex_m.writes && ins_valid && src_hit;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    state_next  = ST_RUN;
    if (mw) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      state_next = ST_MEM_WAIT;
    end else if (br) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_next  = ST_FLUSH;
    end else if (lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      state_next  = ST_LD_STALL;
    end
    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_m        <= META_NONE;
      mem_m       <= META_NONE;
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state <= state_next;
      if (exmem_en) begin
        mem_m <= ex_m;
        ex_m  <= idex_bubble ? META_NONE : id_meta;
      end
      if (state_next != ST_MEM_WAIT) begin
        wait_cnt <= '0;
      end else if (state == ST_MEM_WAIT && !mem_ready && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // Flag sets on the edge where the count lands on MEM_TIMEOUT
      if (state == ST_MEM_WAIT && !mem_ready && wait_cnt == WAIT_LAST) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_en && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a per-cycle vector table for the
// hazard sequences plus hand-written timeout, saturation and reset sequences.
module tb_pipeline_stall_controller;

  localparam int CNT_W = 4;

  localparam logic [5:0] O_NONE = 6'b110011;
  localparam logic [5:0] O_LU   = 6'b000111;
  localparam logic [5:0] O_BR   = 6'b111111;
  localparam logic [5:0] O_MW   = 6'b000000;
  localparam logic [5:0] O_RST  = 6'b001100;

  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        br;
    logic        rdy;
    logic [5:0]  exp_out;
    int          exp_cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      ins_id;
  logic             ins_valid;
  logic             branch_taken_ex;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_en;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;
  logic [5:0]       outs;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl [19];

  assign outs = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en};

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .ins_id          (ins_id),
    .ins_valid       (ins_valid),
    .branch_taken_ex (branch_taken_ex),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .stall_cnt       (stall_cnt),
    .mem_timeout     (mem_timeout)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic v, input logic br,
                               input logic rdy, input logic [5:0] o, input int c);
    vec_t r;
    r.ins = ins; r.v = v; r.br = br; r.rdy = rdy; r.exp_out = o; r.exp_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic br, input logic rdy);
    ins_id = ins; ins_valid = v; branch_taken_ex = br; mem_ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld4, ruse, imm, ld0, r0use, st, xins;
    ld4   = mk(6'b010100, 5'd4, 5'd1, 5'd0);
    ruse  = mk(6'b000000, 5'd5, 5'd1, 5'd4);
    imm   = mk(6'b001101, 5'd6, 5'd1, 5'd0);
    ld0   = mk(6'b010100, 5'd0, 5'd1, 5'd0);
    r0use = mk(6'b000000, 5'd5, 5'd0, 5'd0);
    st    = mk(6'b010101, 5'd0, 5'd2, 5'd3);
    xins  = 'x;

    tbl[0]  = mkv(ld4,   1, 0, 1, O_NONE, 0);
    tbl[1]  = mkv(ruse,  1, 0, 1, O_LU,   0);
    tbl[2]  = mkv(ruse,  1, 0, 1, O_NONE, 1);
    tbl[3]  = mkv(ld4,   1, 0, 1, O_NONE, 1);
    tbl[4]  = mkv(imm,   1, 0, 1, O_NONE, 1);
    tbl[5]  = mkv(ld0,   1, 0, 1, O_NONE, 1);
    tbl[6]  = mkv(r0use, 1, 0, 1, O_NONE, 1);
    tbl[7]  = mkv(xins,  0, 0, 1, O_NONE, 1);
    tbl[8]  = mkv(st,    1, 0, 1, O_NONE, 1);
    tbl[9]  = mkv(xins,  0, 0, 1, O_NONE, 1);
    tbl[10] = mkv(xins,  0, 0, 0, O_MW,   1);
    tbl[11] = mkv(xins,  0, 0, 0, O_MW,   2);
    tbl[12] = mkv(xins,  0, 0, 0, O_MW,   3);
    tbl[13] = mkv(xins,  0, 0, 1, O_NONE, 4);
    tbl[14] = mkv(xins,  0, 0, 1, O_NONE, 4);
    tbl[15] = mkv(ld4,   1, 0, 1, O_NONE, 4);
    tbl[16] = mkv(ruse,  1, 1, 1, O_BR,   4);
    tbl[17] = mkv(ruse,  1, 0, 1, O_NONE, 4);
    tbl[18] = mkv(xins,  0, 0, 1, O_NONE, 4);

    // Reset state
    reset = 1'b0;
    drive(xins, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    #4;
    chk("reset_outs", 32'(outs), 32'(O_RST));
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    $display("reset: outs=%b stall_cnt=%0d mem_timeout=%b", outs, stall_cnt, mem_timeout);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].ins, tbl[i].v, tbl[i].br, tbl[i].rdy);
      #4;
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp_out));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].exp_cnt));
      $display("vec %0d: ins=%h v=%b br=%b rdy=%b outs=%b (exp %b) stall_cnt=%0d (exp %0d)",
               i, tbl[i].ins, tbl[i].v, tbl[i].br, tbl[i].rdy, outs, tbl[i].exp_out,
               stall_cnt, tbl[i].exp_cnt);
      @(negedge clk);
    end

    // Long memory wait: timeout sets, stall counter saturates
    drive(st, 1, 0, 1);
    @(negedge clk);
    drive(xins, 0, 0, 1);
    @(negedge clk);
    drive(xins, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      #4;
      chk($sformatf("wait%0d_outs", k), 32'(outs), 32'(O_MW));
      if (k == 14) chk("timeout_early", 32'(mem_timeout), 32'd0);
      $display("wait %0d: outs=%b mem_timeout=%b stall_cnt=%0d", k, outs, mem_timeout, stall_cnt);
      @(negedge clk);
    end
    #4;
    chk("timeout_set", 32'(mem_timeout), 32'd1);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    $display("after wait: mem_timeout=%b stall_cnt=%0d", mem_timeout, stall_cnt);
    @(negedge clk);

    // Memory completes: pipe moves, flag stays set
    drive(xins, 0, 0, 1);
    #4;
    chk("resume_outs", 32'(outs), 32'(O_NONE));
    chk("timeout_sticky", 32'(mem_timeout), 32'd1);
    $display("resume: outs=%b mem_timeout=%b", outs, mem_timeout);
    @(negedge clk);

    // New wait, then reset dropped in the middle of it
    drive(st, 1, 0, 1);
    @(negedge clk);
    drive(xins, 0, 0, 1);
    @(negedge clk);
    drive(xins, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #4;
    chk("wait2_outs", 32'(outs), 32'(O_MW));
    chk("timeout_sticky2", 32'(mem_timeout), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_outs", 32'(outs), 32'(O_RST));
    chk("midreset_timeout", 32'(mem_timeout), 32'd0);
    chk("midreset_stall_cnt", 32'(stall_cnt), 32'd0);
    $display("mid-wait reset: outs=%b mem_timeout=%b stall_cnt=%0d", outs, mem_timeout, stall_cnt);
    @(negedge clk);
    #4;
    chk("reset_held_outs", 32'(outs), 32'(O_RST));
    @(negedge clk);
    reset = 1'b1;
    #4;
    chk("release_outs", 32'(outs), 32'(O_NONE));
    $display("release: outs=%b", outs);
    @(negedge clk);
    #4;
    chk("release_run_outs", 32'(outs), 32'(O_NONE));
    chk("release_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("release_timeout", 32'(mem_timeout), 32'd0);
    $display("after release: outs=%b stall_cnt=%0d mem_timeout=%b", outs, stall_cnt, mem_timeout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
